// File: rtl/program_sequencer.sv
// Instruction sequencer for the simple processor: holds a small program and
// feeds instruction/immediate words over DIN/Run, advancing on Done.
module program_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 2**ADDR_W,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [15:0]       LoadData,
    input  logic              Done,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  OP_MVI  = 3'b001;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [DATA_W-1:0]   count_nxt;
    logic [WD_W-1:0]     wd, wd_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   imm_word;
    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   pc_inc1;
    logic [ADDR_W-1:0]   pc_inc2;

    assign pc_inc1  = PC + ADDR_W'(1);
    assign pc_inc2  = PC + ADDR_W'(2);
    assign cur_word = mem[PC];
    assign imm_word = mem[pc_inc1];
    assign opcode   = cur_word[8:6];

    assign Busy   = (state == S_ISSUE) || (state == S_EXEC);
    assign Halted = (state == S_HALTED);
    assign Error  = (state == S_ERROR);

    // Program memory: host writes are blocked while a program is running.
    always_ff @(posedge Clock) begin
        if (LoadEn && !Busy) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            PC         <= '0;
            InstrCount <= '0;
            wd         <= '0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            InstrCount <= count_nxt;
            wd         <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        count_nxt = InstrCount;
        wd_nxt    = wd;
        Run       = 1'b0;
        DIN       = '0;
        case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (Start) begin
                    state_nxt = S_ISSUE;
                    pc_nxt    = '0;
                    count_nxt = '0;
                end
            end
            S_ISSUE: begin
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALTED;
                end else if (opcode[2]) begin
                    // Unsupported opcodes are stepped over without touching the processor.
                    pc_nxt = pc_inc1;
                end else begin
                    DIN       = cur_word;
                    Run       = 1'b1;
                    state_nxt = S_EXEC;
                    wd_nxt    = '0;
                end
            end
            S_EXEC: begin
                if (opcode == OP_MVI) begin
                    DIN = imm_word;
                end
                if (Done) begin
                    pc_nxt    = (opcode == OP_MVI) ? pc_inc2 : pc_inc1;
                    count_nxt = InstrCount + DATA_W'(1);
                    state_nxt = S_ISSUE;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    state_nxt = S_ERROR;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a small model of the simple
// processor supplying Done and holding the register file.
module tb_program_sequencer;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic        LoadEn;
    logic [4:0]  LoadAddr;
    logic [15:0] LoadData;
    logic        Done;
    logic [15:0] DIN;
    logic        Run;
    logic        Busy;
    logic        Halted;
    logic        Error;
    logic [4:0]  PC;
    logic [15:0] InstrCount;

    int n_checks = 0;
    int n_fail   = 0;

    program_sequencer #(.ADDR_W(5), .DEPTH(32), .TIMEOUT(4)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .Done       (Done),
        .DIN        (DIN),
        .Run        (Run),
        .Busy       (Busy),
        .Halted     (Halted),
        .Error      (Error),
        .PC         (PC),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Processor model: step 0 latches the instruction on Run; mv/mvi finish
    // in step 1, add/sub in step 3. Done is high whenever it is idle.
    logic [1:0]  step;
    logic [8:0]  ir;
    logic [15:0] rf [8];
    logic [15:0] areg, greg;
    logic        proc_done;
    logic        tie_done_low;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step <= 2'd0;
            ir   <= '0;
            areg <= '0;
            greg <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (step)
                2'd0: if (Run) begin
                    ir   <= DIN[8:0];
                    step <= 2'd1;
                end
                2'd1: begin
                    if (ir[8:6] == 3'b000) begin
                        rf[ir[5:3]] <= rf[ir[2:0]];
                        step <= 2'd0;
                    end else if (ir[8:6] == 3'b001) begin
                        rf[ir[5:3]] <= DIN;
                        step <= 2'd0;
                    end else begin
                        areg <= rf[ir[5:3]];
                        step <= 2'd2;
                    end
                end
                2'd2: begin
                    greg <= (ir[8:6] == 3'b011) ? areg - rf[ir[2:0]] : areg + rf[ir[2:0]];
                    step <= 2'd3;
                end
                default: begin
                    rf[ir[5:3]] <= greg;
                    step <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        case (step)
            2'd0:    proc_done = 1'b1;
            2'd1:    proc_done = (ir[8:7] == 2'b00);
            2'd2:    proc_done = 1'b0;
            default: proc_done = 1'b1;
        endcase
    end

    assign Done = tie_done_low ? 1'b0 : proc_done;

    logic        run_log    [64];
    logic [15:0] din_log    [64];
    logic        halted_log [64];
    logic        error_log  [64];
    logic        busy_log   [64];
    logic [4:0]  pc_log     [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [4:0] addr, input logic [15:0] data);
        @(negedge Clock);
        LoadEn   = 1'b1;
        LoadAddr = addr;
        LoadData = data;
        @(negedge Clock);
        LoadEn   = 1'b0;
    endtask

    // Pulse Start for cycle 0, then sample cycles 1..n at the falling edge.
    task automatic start_and_log(input int n);
        @(negedge Clock);
        Start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge Clock);
            Start         = 1'b0;
            run_log[k]    = Run;
            din_log[k]    = DIN;
            halted_log[k] = Halted;
            error_log[k]  = Error;
            busy_log[k]   = Busy;
            pc_log[k]     = PC;
        end
    endtask

    function automatic logic [31:0] run_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int k = 1; k <= n; k++) m[k] = run_log[k];
        return m;
    endfunction

    task automatic wait_halt(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge Clock);
            if (Halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ok;
        Resetn       = 1'b0;
        Start        = 1'b0;
        LoadEn       = 1'b0;
        LoadAddr     = '0;
        LoadData     = '0;
        tie_done_low = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_busy",   32'(Busy), 0);
        check("rst_halted", 32'(Halted), 0);
        check("rst_error",  32'(Error), 0);
        check("rst_run",    32'(Run), 0);
        check("rst_din",    32'(DIN), 0);
        check("rst_pc",     32'(PC), 0);
        check("rst_count",  32'(InstrCount), 0);
        Resetn = 1'b1;

        // mvi R0,5 ; mvi R1,3 ; add R0,R1 ; halt
        load_word(5'd0, 16'h0040);
        load_word(5'd1, 16'd5);
        load_word(5'd2, 16'h0048);
        load_word(5'd3, 16'd3);
        load_word(5'd4, 16'h0081);
        load_word(5'd5, 16'h01C0);
        start_and_log(12);
        check("add_run_mask", run_mask(12), 32'h0000_002A);
        check("add_din_c2",   32'(din_log[2]), 5);
        check("add_din_c4",   32'(din_log[4]), 3);
        check("add_busy_c9",  32'(busy_log[9]), 1);
        check("add_halt_c9",  32'(halted_log[9]), 0);
        check("add_halt_c10", 32'(halted_log[10]), 1);
        check("add_pc",       32'(PC), 5);
        check("add_count",    32'(InstrCount), 3);
        check("add_r0",       32'(rf[0]), 8);

        // Same program with sub R0,R1
        load_word(5'd4, 16'h00C1);
        start_and_log(12);
        check("sub_run_mask", run_mask(12), 32'h0000_002A);
        check("sub_halt_c9",  32'(halted_log[9]), 0);
        check("sub_halt_c10", 32'(halted_log[10]), 1);
        check("sub_r0",       32'(rf[0]), 2);
        check("sub_count",    32'(InstrCount), 3);

        // Skipped word followed by HALT
        load_word(5'd0, 16'h0100);
        load_word(5'd1, 16'h01C0);
        start_and_log(4);
        check("skip_run_mask", run_mask(4), 0);
        check("skip_halt_c2",  32'(halted_log[2]), 0);
        check("skip_halt_c3",  32'(halted_log[3]), 1);
        check("skip_pc",       32'(PC), 1);
        check("skip_count",    32'(InstrCount), 0);

        // HALT as the first word
        load_word(5'd0, 16'h01C0);
        start_and_log(3);
        check("hfirst_halt_c1", 32'(halted_log[1]), 0);
        check("hfirst_halt_c2", 32'(halted_log[2]), 1);
        check("hfirst_pc",      32'(PC), 0);
        check("hfirst_count",   32'(InstrCount), 0);

        // Watchdog: Done never arrives
        load_word(5'd0, 16'h0081);
        tie_done_low = 1'b1;
        start_and_log(6);
        check("to_run_c1",   32'(run_log[1]), 1);
        check("to_err_c5",   32'(error_log[5]), 0);
        check("to_busy_c5",  32'(busy_log[5]), 1);
        check("to_err_c6",   32'(error_log[6]), 1);
        check("to_busy_c6",  32'(busy_log[6]), 0);
        check("to_pc_c6",    32'(pc_log[6]), 0);
        tie_done_low = 1'b0;
        load_word(5'd0, 16'h01C0);
        start_and_log(2);
        check("to_restart_err",  32'(error_log[1]), 0);
        check("to_restart_busy", 32'(busy_log[1]), 1);
        check("to_restart_pc",   32'(pc_log[1]), 0);
        check("to_restart_halt", 32'(halted_log[2]), 1);

        // PC wrap: mvi R2 at 0 (imm = HALT word at 1), skips 2..30, mvi R3 at 31 with imm at 0
        load_word(5'd0, 16'h0050);
        load_word(5'd1, 16'h01C0);
        for (int a = 2; a <= 30; a++) load_word(5'(a), 16'h0100);
        load_word(5'd31, 16'h0058);
        start_and_log(36);
        check("wrap_din_c2",   32'(din_log[2]), 32'h01C0);
        check("wrap_pc_c32",   32'(pc_log[32]), 31);
        check("wrap_run_c32",  32'(run_log[32]), 1);
        check("wrap_din_c33",  32'(din_log[33]), 32'h0050);
        check("wrap_halt_c34", 32'(halted_log[34]), 0);
        check("wrap_halt_c35", 32'(halted_log[35]), 1);
        check("wrap_pc",       32'(PC), 1);
        check("wrap_count",    32'(InstrCount), 2);
        check("wrap_r3",       32'(rf[3]), 32'h0050);

        // Load attempt while busy must not overwrite the HALT at address 1
        load_word(5'd0, 16'h0081);
        load_word(5'd1, 16'h01C0);
        load_word(5'd2, 16'h01C0);
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        check("ld_busy", 32'(Busy), 1);
        LoadEn   = 1'b1;
        LoadAddr = 5'd1;
        LoadData = 16'h0000;
        @(negedge Clock);
        LoadEn = 1'b0;
        wait_halt(20, ok);
        check("ld_halt_wait", 32'(ok), 1);
        check("ld_pc",        32'(PC), 1);
        check("ld_count",     32'(InstrCount), 1);

        // Asynchronous reset while the add is being issued
        load_word(5'd0, 16'h0040);
        load_word(5'd1, 16'd7);
        load_word(5'd2, 16'h0081);
        load_word(5'd3, 16'h01C0);
        start_and_log(3);
        check("rst_mid_run_pre",   32'(run_log[3]), 1);
        check("rst_mid_pc_pre",    32'(pc_log[3]), 2);
        check("rst_mid_count_pre", 32'(InstrCount), 1);
        #1 Resetn = 1'b0;
        #1;
        check("rst_mid_run",   32'(Run), 0);
        check("rst_mid_busy",  32'(Busy), 0);
        check("rst_mid_pc",    32'(PC), 0);
        check("rst_mid_count", 32'(InstrCount), 0);
        check("rst_mid_din",   32'(DIN), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Instruction-side counterpart of the simple processor: stores a small program and drives the processor's DIN/Run inputs.
- Supplies each instruction word, plus the immediate word for mvi, and waits on the processor's Done before advancing its program counter.
- Sits between a host load port and the processor.
- Stops on a HALT opcode or on a protocol timeout.

Parameters:
- ADDR_W, 5, program-memory address width.
- DEPTH, 32, program words (2**ADDR_W).
- TIMEOUT, 4, maximum EXEC cycles allowed without Done before ERROR.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset; the same net resets the processor.
- Start  in  1  one-cycle pulse that begins execution at address 0 from IDLE, HALTED or ERROR.
- LoadEn  in  1  program-memory write enable.
- LoadAddr  in  ADDR_W  write address.
- LoadData  in  16  write data.
- Done  in  1  processor end-of-instruction flag.
- DIN  out  16  word presented to the processor.
- Run  out  1  instruction-valid strobe to the processor.
- Busy  out  1  high in ISSUE or EXEC.
- Halted  out  1  high in HALTED.
- Error  out  1  high in ERROR.
- PC  out  ADDR_W  current program counter.
- InstrCount  out  16  instructions retired since Start, wraps.

Behaviour:
- Clock and reset:
  - One clock: Clock.
  - Resetn is asynchronous, active-low.
  - Reset values: state IDLE, PC=0, InstrCount=0, watchdog=0, Run=0, DIN=0, Busy=0, Halted=0, Error=0.
  - Program memory is not reset.
- Instruction word format:
  - DIN[8:6] = opcode: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT, 100–110 skipped.
  - DIN[5:3] = X register; DIN[2:0] = Y register.
- Load port:
  - Write occurs on the rising edge when LoadEn=1 and Busy=0.
  - LoadEn is ignored while Busy=1.
  - A load in the same cycle as Start is performed; execution begins the next cycle.
- States: IDLE, ISSUE, EXEC, HALTED, ERROR.
- IDLE / HALTED / ERROR:
  - Run=0, DIN=0.
  - Start → PC=0, InstrCount=0, Error and Halted cleared, next state ISSUE.
  - Done is ignored in these states; the processor holds Done high while idle.
- ISSUE (outputs combinational from state and mem[PC]):
  - Opcode 000–011: DIN=mem[PC], Run=1; next state EXEC with watchdog=0.
  - Opcode 111: Run=0; next state HALTED; PC unchanged, pointing at the HALT word.
  - Opcode 100–110: Run=0; PC=PC+1; remain in ISSUE. No retire; no processor activity.
- EXEC:
  - Run=0.
  - For mvi: DIN=mem[(PC+1) mod DEPTH], the immediate, consumed by the processor in its step 1. Otherwise DIN=0.
  - On Done=1:
    - PC advances by 2 for mvi, 1 otherwise, modulo DEPTH.
    - InstrCount+1.
    - Next state ISSUE. The processor is at step 0 in that next cycle, so instructions run back-to-back.
  - Otherwise watchdog+1. When watchdog reaches TIMEOUT: next state ERROR, Error=1, PC held at the faulting instruction.
- Cycle counts per instruction, ISSUE + EXEC: mv 2, mvi 2, add 4, sub 4. Each skipped word costs 1 cycle; HALT costs 1 cycle.
- PC wrap: PC=DEPTH-1 with mvi reads its immediate from address 0; the next PC is 1.
- Start while Busy is ignored.
- Resetn low mid-instruction returns to IDLE immediately; Run drops asynchronously.

Test Plan:
- Program: mem[0]=0x040, mem[1]=5, mem[2]=0x048, mem[3]=3, mem[4]=0x081, mem[5]=0x1C0; pulse Start.
  - Run high exactly in cycles 1, 3 and 5 after Start.
  - DIN=5 at cycle 2 and DIN=3 at cycle 4.
  - Halted=1 from cycle 10; PC=5; InstrCount=3; the processor's R0 holds 8.
- Replace mem[4] with 0x0C1 (sub R0,R1) → R0=2 at halt; the sub occupies 4 cycles.
- Skip and HALT-first:
  - mem[0]=0x100, mem[1]=0x1C0, Start → Run never asserted; Halted after 2 cycles; PC=1; InstrCount=0.
  - mem[0]=0x1C0, Start → Halted after 1 cycle; InstrCount=0.
- Timeout: tie Done low, mem[0]=0x081 → Error=1 after 1 ISSUE + 4 EXEC cycles; PC=0; Busy=0; a following Start clears Error and restarts at 0.
- Wrap: mvi at address 31 with immediate at address 0, HALT at address 1 → DIN equals mem[0] during EXEC; final PC=1.
- Load rejection and reset:
  - LoadEn pulsed while Busy → memory contents unchanged.
  - Resetn pulsed low mid-add → IDLE, Run=0, PC=0, InstrCount=0 with no clock edge required.
